// File: rtl/bsg_credit_to_ready_flow_converter_if.sv
// Link/downstream bundle for the credit-to-ready converter.
//   link_v, link_data : incoming beats from the credit link (no backpressure)
//   credit            : one credit returned to the transmitter per cycle when high
//   v, data           : FIFO head presented downstream
//   ready             : downstream accepts the head (pop = v & ready)
// The master modport is the converter; the slave modport is its environment
// (transmitter on one side, consumer on the other).
interface bsg_credit_to_ready_flow_converter_if #(
    parameter int width_p = 8
);
    logic               link_v;
    logic [width_p-1:0] link_data;
    logic               credit;
    logic               v;
    logic [width_p-1:0] data;
    logic               ready;

    modport master (
        input  link_v, link_data, ready,
        output credit, v, data
    );

    modport slave (
        output link_v, link_data, ready,
        input  credit, v, data
    );
endinterface

// File: rtl/bsg_credit_rx_fifo.sv
// Receive FIFO for the credit link: els_p x width_p storage with
// read/write pointers that wrap at els_p (not necessarily a power of two),
// an occupancy counter and full/empty indication.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   enq_i, data_i    : write data_i at the tail (caller never enqueues into a
//                      full FIFO unless it also dequeues this cycle)
//   deq_i            : pop the head (caller only pops when v_o is high)
//   v_o, data_o      : FIFO non-empty and head entry
//   full_o           : occupancy == els_p
module bsg_credit_rx_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 10
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);
    localparam int lg_els_lp = $clog2(els_p + 1);
    localparam int ptr_w_lp  = $clog2(els_p);

    logic [width_p-1:0]   mem [els_p];
    logic [ptr_w_lp-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [ptr_w_lp-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [lg_els_lp-1:0] count_reg, count_next;

    // Storage carries no reset: pointers and count define what is valid.
    // When full with enq+deq, the write lands on the slot being read out in
    // the same cycle; the head is read combinationally before the edge.
    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (deq_i) begin
            rd_ptr_next = (rd_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (enq_i) begin
            wr_ptr_next = (wr_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (enq_i && !deq_i) begin
            count_next = count_reg + 1'b1;
        end else if (deq_i && !enq_i) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign v_o    = (count_reg != '0);
    assign full_o = (count_reg == lg_els_lp'(els_p));
    assign data_o = mem[rd_ptr_reg];
endmodule

// File: rtl/bsg_credit_to_ready_flow_converter.sv
// Receiver end of a credit-based link. Beats arriving on the link are
// buffered in an els_p-entry FIFO and offered downstream with valid/ready.
// Each popped entry returns one credit; after reset els_p credits are issued
// so the transmitter's counter climbs from 0 to els_p.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   link (master)    : link_v/link_data in, credit out, v/data out, ready in
//   overflow_o       : sticky; a beat arrived while the FIFO was full and
//                      nothing was popped in that cycle
module bsg_credit_to_ready_flow_converter #(
    parameter int width_p = 8,
    parameter int els_p   = 10
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_credit_to_ready_flow_converter_if.master link,
    output logic overflow_o
);
    localparam int lg_els_lp = $clog2(els_p + 1);

    logic                 fifo_v;
    logic [width_p-1:0]   fifo_data;
    logic                 fifo_full;
    logic                 deq;
    logic                 enq;
    logic                 drop;
    logic                 credit;
    logic [lg_els_lp-1:0] pending_reg, pending_next;
    logic [lg_els_lp:0]   pending_wide;
    logic                 overflow_reg, overflow_next;

    assign deq  = fifo_v & link.ready;
    // A pop in the same cycle frees room, so a full FIFO can still accept.
    assign enq  = link.link_v & (~fifo_full | deq);
    assign drop = link.link_v & fifo_full & ~deq;

    bsg_credit_rx_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (enq),
        .data_i    (link.link_data),
        .deq_i     (deq),
        .v_o       (fifo_v),
        .data_o    (fifo_data),
        .full_o    (fifo_full)
    );

    // Credits leave straight from the register; a pop in the same cycle
    // replaces the one just sent, so the train extends by one per pop.
    assign credit       = (pending_reg != '0);
    assign pending_wide = {1'b0, pending_reg} - (lg_els_lp + 1)'(credit)
                        + (lg_els_lp + 1)'(deq);

    always_comb begin
        pending_next  = pending_wide[lg_els_lp-1:0];
        overflow_next = overflow_reg | drop;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_reg  <= lg_els_lp'(els_p);
            overflow_reg <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
        end
    end

    assign link.credit = credit;
    assign link.v      = fifo_v;
    assign link.data   = fifo_data;
    assign overflow_o  = overflow_reg;

    // Pending credits plus FIFO occupancy can never exceed els_p, and a
    // credit is only sent when one is held.
    a_pending_max: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        pending_wide <= (lg_els_lp + 1)'(els_p));
    a_pending_min: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ({1'b0, pending_reg} + (lg_els_lp + 1)'(deq)) >= (lg_els_lp + 1)'(credit));
endmodule

// File: tb/tb_bsg_credit_to_ready_flow_converter.sv
module tb_bsg_credit_to_ready_flow_converter;
    localparam int width_p = 8;
    localparam int els_p   = 10;

    logic clk_i = 1'b0;
    logic reset_n_i;
    logic overflow_o;

    always #5 clk_i = ~clk_i;

    bsg_credit_to_ready_flow_converter_if #(.width_p(width_p)) link ();

    bsg_credit_to_ready_flow_converter #(
        .width_p (width_p),
        .els_p   (els_p)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .link       (link.master),
        .overflow_o (overflow_o)
    );

    // Scoreboard and reference state.
    logic [width_p-1:0] sb_q[$];
    int  m_pending;
    bit  m_ovf;
    int  checks_total  = 0;
    int  checks_passed = 0;
    int  credits_seen  = 0;
    int  pops          = 0;
    int  aa_pop_idx    = -1;
    bit  bb_seen       = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks_total++;
        if (obs == exp) checks_passed++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // One cycle, entered and left at a falling edge: drive, check, advance model.
    task automatic step(input bit v, input logic [width_p-1:0] d, input bit rdy);
        bit deq;
        logic [width_p-1:0] head;
        link.link_v    = v;
        link.link_data = d;
        link.ready     = rdy;
        #1;
        check("v_o", int'(link.v), int'(sb_q.size() != 0));
        if (sb_q.size() != 0) check("data_o", int'(link.data), int'(sb_q[0]));
        check("credit_o", int'(link.credit), int'(m_pending != 0));
        check("overflow_o", int'(overflow_o), int'(m_ovf));
        if (link.credit) credits_seen++;

        deq = (sb_q.size() != 0) && rdy;
        if (deq) begin
            head = sb_q.pop_front();
            $display("pop %0d: data 0x%02h", pops, head);
            if (head == 8'hAA) aa_pop_idx = pops;
            if (head == 8'hBB) bb_seen = 1;
            pops++;
        end
        if (v) begin
            if (sb_q.size() < els_p) begin
                sb_q.push_back(d);
                $display("push: data 0x%02h", d);
            end else begin
                m_ovf = 1;
                $display("drop: data 0x%02h (full)", d);
            end
        end
        m_pending = m_pending - ((m_pending != 0) ? 1 : 0) + (deq ? 1 : 0);
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_pending = els_p;
        m_ovf     = 0;
    endtask

    initial begin
        reset_n_i      = 1'b0;
        link.link_v    = 1'b0;
        link.link_data = '0;
        link.ready     = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_v_o", int'(link.v), 0);
        check("reset_overflow", int'(overflow_o), 0);

        // Initial grant: exactly els_p credit pulses with no traffic.
        reset_n_i    = 1'b1;
        credits_seen = 0;
        for (int i = 0; i < els_p + 4; i++) step(0, '0, 0);
        check("initial_credits", credits_seen, els_p);

        // Three beats held with ready low, then drained.
        credits_seen = 0;
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        check("no_credit_while_held", credits_seen, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 0);
        check("credits_after_pops", credits_seen, 3);

        // Fill, then simultaneous enq+deq at full.
        for (int i = 0; i < els_p; i++) step(1, 8'h40 + 8'(i), 0);
        check("full_occupancy", sb_q.size(), els_p);
        step(1, 8'hAA, 1);
        // Full with no pop: beat dropped, overflow sticks.
        credits_seen = 0;
        step(1, 8'hBB, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        check("pending_unchanged_on_drop", credits_seen, 1);
        aa_pop_idx = -1;
        pops       = 0;
        for (int i = 0; i < els_p + 2; i++) step(0, '0, 1);
        check("aa_after_9_pops", aa_pop_idx, 9);
        check("bb_never_output", int'(bb_seen), 0);
        check("overflow_sticky", int'(overflow_o), 1);

        // Async reset with entries held.
        for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0);
        for (int i = 0; i < 12; i++) step(0, '0, 0);
        check("held_before_reset", int'(link.v), 1);
        #2 reset_n_i = 1'b0;
        #1;
        check("async_reset_v_o", int'(link.v), 0);
        check("async_reset_overflow", int'(overflow_o), 0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i    = 1'b1;
        credits_seen = 0;
        for (int i = 0; i < els_p + 3; i++) step(0, '0, 0);
        check("regrant_credits", credits_seen, els_p);

        // Light random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            step(bit'($urandom_range(0, 1)) && (sb_q.size() < els_p),
                 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
